// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode encodings and RV32I decode constants
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SLT  = 4'b1001
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_t     op;
        logic [4:0]  rd;
        logic        illegal;
    } alu_req_t;

endpackage

// File: rtl/rv32i_alu_dec.sv
// rtl/rv32i_alu_dec.sv - combinational RV32I ALU-class decode to operands and opcode
module rv32i_alu_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output alu_op_t     op_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] shamt;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign shamt  = {27'b0, instr_i[24:20]};

    logic [31:0] a_raw;
    logic [31:0] b_raw;
    alu_op_t     op_raw;
    logic        bad;

    always_comb begin
        a_raw  = '0;
        b_raw  = '0;
        op_raw = ALU_ADD;
        bad    = 1'b0;
        case (opcode)
            OPC_OP: begin
                a_raw = rs1_i;
                b_raw = rs2_i;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: op_raw = ALU_ADD;
                        F3_SLL:     op_raw = ALU_SLL;
                        F3_SLT:     op_raw = ALU_SLT;
                        F3_SLTU:    op_raw = ALU_SLTU;
                        F3_XOR:     op_raw = ALU_XOR;
                        F3_SRL_SRA: op_raw = ALU_SRL;
                        F3_OR:      op_raw = ALU_OR;
                        F3_AND:     op_raw = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    op_raw = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    op_raw = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                a_raw = rs1_i;
                b_raw = imm_i;
                case (funct3)
                    F3_ADD_SUB: op_raw = ALU_ADD;
                    F3_SLT:     op_raw = ALU_SLT;
                    F3_SLTU:    op_raw = ALU_SLTU;
                    F3_XOR:     op_raw = ALU_XOR;
                    F3_OR:      op_raw = ALU_OR;
                    F3_AND:     op_raw = ALU_AND;
                    F3_SLL: begin
                        b_raw  = shamt;
                        op_raw = ALU_SLL;
                        bad    = (funct7 != F7_BASE);
                    end
                    F3_SRL_SRA: begin
                        b_raw = shamt;
                        if (funct7 == F7_BASE) begin
                            op_raw = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            op_raw = ALU_SRA;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                b_raw = {instr_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                a_raw = pc_i;
                b_raw = {instr_i[31:12], 12'b0};
            end
            default: bad = 1'b1;
        endcase
    end

    // Illegal instructions present a canonical all-zero ADD so nothing downstream sees stale operands.
    assign a_o       = bad ? 32'b0 : a_raw;
    assign b_o       = bad ? 32'b0 : b_raw;
    assign op_o      = bad ? ALU_ADD : op_raw;
    assign rd_o      = bad ? 5'b0 : instr_i[11:7];
    assign illegal_o = bad;

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue stage: decode, output register plus skid buffer, illegal counter
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_alu_op,
    output logic [4:0]  out_rd,
    output logic        out_illegal,
    output logic [15:0] illegal_cnt
);

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    alu_op_t     dec_op;
    logic [4:0]  dec_rd;
    logic        dec_illegal;
    alu_req_t    dec_req;

    rv32i_alu_dec u_dec (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .rs1_i     (in_rs1_val),
        .rs2_i     (in_rs2_val),
        .a_o       (dec_a),
        .b_o       (dec_b),
        .op_o      (dec_op),
        .rd_o      (dec_rd),
        .illegal_o (dec_illegal)
    );

    assign dec_req = '{a: dec_a, b: dec_b, op: dec_op, rd: dec_rd, illegal: dec_illegal};

    alu_req_t    out_q, out_d;
    alu_req_t    skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        in_ready_q, in_ready_d;
    logic [15:0] cnt_q, cnt_d;
    logic        accept;

    assign accept = in_valid && in_ready_q;

    // in_ready tracks "skid empty", so an accept can never coincide with a full skid.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_req;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_req;
            skid_valid_d = 1'b1;
        end
        if (accept && dec_illegal && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_alu_op  = out_q.op;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 SHALL have: in_valid  input  1  upstream instruction valid.
REQ-003 SHALL have: in_ready  output  1  block can accept this cycle.
REQ-004 SHALL have: in_instr  input  32  RV32I instruction word.
REQ-005 SHALL have: in_pc  input  32  instruction address (AUIPC operand).
REQ-006 SHALL have: in_rs1_val, in_rs2_val  input  32 each  register operand values.
REQ-007 SHALL have: out_valid  output  1  decoded ALU request valid.
REQ-008 SHALL have: out_ready  input  1  downstream (ALU/writeback) accepts.
REQ-009 SHALL have: out_a, out_b  output  32 each  ALU operands; out_alu_op  output  4  ALU opcode.
REQ-010 SHALL have: out_rd  output  5  destination register; out_illegal  output  1  instruction not decodable.
REQ-011 SHALL have: illegal_cnt  output  16  saturating count of illegal instructions accepted.

Function
REQ-012 SHALL use ALU encoding ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLTU 1000, SLT 1001.
REQ-013 OP (0110011): a=rs1, b=rs2; funct3/funct7 map ADD/SUB (f7 0000000/0100000), SLL, SLT, SLTU, XOR, SRL/SRA (f7 0000000/0100000), OR, AND; any other funct7 is illegal.
REQ-014 OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20] for ADDI/SLTI/SLTIU/XORI/ORI/ANDI; SLLI/SRLI/SRAI b={27'b0,instr[24:20]}, instr[31:25] must be 0000000 (SLLI, SRLI) or 0100000 (SRAI), else illegal.
REQ-015 LUI (0110111): a=0, b={instr[31:12],12'b0}, ADD; AUIPC (0010111): a=in_pc, same b, ADD.
REQ-016 Any other opcode, or illegal funct: out_illegal=1, out_alu_op=ADD, out_a=out_b=0, out_rd=0.
REQ-017 Transfer occurs on valid&&ready at a rising edge, on each side independently.
REQ-018 Latency: accepted instruction SHALL appear on outputs with out_valid=1 on the next cycle when the output stage is empty or draining.
REQ-019 SHALL hold an output register plus one skid register (2 entries); in_ready SHALL be a register output equal to "skid empty".
REQ-020 Output stalled (out_valid&&!out_ready) and new accept: entry goes to skid; in_ready deasserts next cycle.
REQ-021 Output consumed while skid full: skid moves to output same edge; in_ready reasserts next cycle; no new accept that cycle is possible (in_ready already low).
REQ-022 Output consumed, skid empty, simultaneous accept: new entry loads output directly, out_valid stays 1.
REQ-023 Outputs SHALL remain stable while out_valid&&!out_ready; order strictly FIFO; no loss or duplication.
REQ-024 illegal_cnt SHALL increment on accept of an illegal instruction, saturating at 0xFFFF.

Reset
REQ-025 rst_n low SHALL asynchronously force out_valid=0, in_ready=0, skid empty, illegal_cnt=0, out_a=out_b=0, out_alu_op=0000, out_rd=0, out_illegal=0.
REQ-026 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-transfer discards all held entries.

Structure
REQ-027 alu_pkg SHALL hold the alu_op_t enum (REQ-012 encodings) and RV32I opcode/funct constants, shared with the ALU.
REQ-028 Combinational decode SHALL live in sub-module rv32i_alu_dec (instr, pc, rs1, rs2 -> a, b, op, rd, illegal); alu_issue adds the handshake, skid and counter.

Verification
REQ-029 0x002081B3 (ADD x3,x1,x2), rs1=5, rs2=7 -> next cycle out_valid=1, op 0000, a=5, b=7, rd=3.
REQ-030 0x40435293 (SRAI x5,x6,4), rs1=0x80000000 -> op 0111, a=0x80000000, b=4, rd=5; 0xFFF00093 (ADDI x1,x0,-1) -> b=0xFFFFFFFF, rd=1.
REQ-031 out_ready=0, three back-to-back valid instrs -> two accepted, in_ready=0 after second; out_ready=1 -> all three emitted in order, no duplicates.
REQ-032 0x00000000 and 0x02208033 (bad funct7) -> out_illegal=1, op 0000, a=b=0, rd=0, illegal_cnt +1 each; preload 0xFFFF -> stays 0xFFFF.
REQ-033 rst_n low while out_valid=1 and skid full -> out_valid=0, in_ready=0 immediately; after release in_ready=1 one cycle later, no stale output.
